// File: rtl/keypad_scanner.sv
// +----------------------------------------------------------------------------+
// | keypad_scanner: 4x4 matrix keypad scan, debounce and key-code FIFO with a   |
// | CPU status/data read port. Optional auto-repeat: define KEYSCAN_REPEAT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rowwrite,
  input  logic [3:0] colread,
  input  logic       ack,
  input  logic       statusordata,
  output logic [3:0] keyout
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_db_max   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] c_db_one   = CNT_W'(1);
  localparam logic [4:0]       c_none     = 5'b0_0000;
  localparam bit c_cfg_ok = (SCAN_DIV >= 2) && (DEBOUNCE_SCANS >= 1) &&
                            (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                            (REPEAT_SCANS >= 1);

  // An illegal configuration instantiates a module that does not exist.
  if (!c_cfg_ok) begin : g_cfg_err
    keypad_scanner_illegal_parameters u_cfg_err ();
  end

  logic [3:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic             found_q;
  logic [3:0]       fcode_q;
  logic [4:0]       prev_q, prev_d;
  logic [4:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_q, push_d;
  logic             ack_q;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             ovf_q;

  logic       w_sample, w_frame_end, w_col_hit;
  logic [1:0] w_col_idx;
  logic [4:0] w_res;
  logic       w_empty, w_full, w_pop, w_push_ok;

  assign rowwrite    = ~(4'b0001 << row_q);
  assign w_sample    = (div_q == c_div_last);
  assign w_frame_end = w_sample && (row_q == 2'd3);
  assign w_col_hit   = ~&col_s2_q;

  always_comb begin
    w_col_idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s2_q[c]) w_col_idx = 2'(c);
    end
  end

  // Rows are scanned in ascending order, so the first hit of a frame is the lowest code.
  always_comb begin
    w_res = c_none;
    if (found_q)        w_res = {1'b1, fcode_q};
    else if (w_col_hit) w_res = {1'b1, row_q, w_col_idx};
  end

`ifdef KEYSCAN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] c_rep_last = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    push_d   = 1'b0;
`ifdef KEYSCAN_REPEAT_EN
    rep_d    = rep_q;
`endif
    if (w_frame_end) begin
      prev_d = w_res;
      if (w_res == prev_q) cnt_d = (cnt_q == c_db_max) ? cnt_q : cnt_q + c_db_one;
      else                 cnt_d = c_db_one;
      if ((cnt_d == c_db_max) && (w_res != stable_q)) begin
        stable_d = w_res;
        push_d   = w_res[4];
`ifdef KEYSCAN_REPEAT_EN
        rep_d    = '0;
`endif
      end
`ifdef KEYSCAN_REPEAT_EN
      else if (stable_q[4]) begin
        if (rep_q == c_rep_last) begin
          rep_d  = '0;
          push_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
`endif
    end
  end

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign w_pop     = ack && !ack_q && !w_empty;
  assign w_push_ok = push_q && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      div_q    <= '0;
      row_q    <= 2'd0;
      found_q  <= 1'b0;
      fcode_q  <= 4'h0;
      prev_q   <= c_none;
      stable_q <= c_none;
      cnt_q    <= '0;
      push_q   <= 1'b0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef KEYSCAN_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      col_s1_q <= colread;
      col_s2_q <= col_s1_q;
      if (w_sample) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (w_frame_end) begin
        found_q <= 1'b0;
      end else if (w_sample && !found_q && w_col_hit) begin
        found_q <= 1'b1;
        fcode_q <= {row_q, w_col_idx};
      end
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      push_q   <= push_d;
      ack_q    <= ack;
`ifdef KEYSCAN_REPEAT_EN
      rep_q    <= rep_d;
`endif
      if (w_pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_push_ok)   wr_ptr_q <= wr_ptr_q + 1'b1;
      // A pop in the same cycle as a push onto a full FIFO makes room, so no overflow.
      if (w_pop)       ovf_q <= 1'b0;
      else if (push_q && w_full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= stable_q[3:0];
  end

  always_comb begin
    if (statusordata) keyout = {ovf_q, 2'b00, ~w_empty};
    else if (w_empty) keyout = 4'h0;
    else              keyout = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner: directed self-checking bench for keypad_scanner with     |
// | SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, REPEAT_SCANS=5 (16-cycle frame).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        ack = 1'b0;
  logic        statusordata = 1'b0;
  logic [3:0]  keyout;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3),
    .FIFO_DEPTH    (4),
    .REPEAT_SCANS  (5)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rowwrite    (rowwrite),
    .colread     (colread),
    .ack         (ack),
    .statusordata(statusordata),
    .keyout      (keyout)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rowwrite[r] && keys[4*r+c]) colread[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_status(input string tag, input logic [3:0] exp);
    statusordata = 1'b1;
    #1;
    check(tag, keyout, exp);
  endtask

  task automatic chk_data(input string tag, input logic [3:0] exp);
    statusordata = 1'b0;
    #1;
    check(tag, keyout, exp);
  endtask

  task automatic pop();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
  endtask

  task automatic tap(input int k);
    keys = 16'h0001 << k;
    cyc(80);
    keys = 16'h0000;
    cyc(80);
  endtask

  initial begin
    logic [3:0] last;
    logic       aligned;
    logic [3:0] row_exp [4];
    row_exp[0] = 4'b1110;
    row_exp[1] = 4'b1101;
    row_exp[2] = 4'b1011;
    row_exp[3] = 4'b0111;

    // Reset release and idle scan
    cyc(3);
    rst = 1'b0;
    check("row0", rowwrite, row_exp[0]);
    for (int i = 1; i < 4; i++) begin
      cyc(4);
      check("row_seq", rowwrite, row_exp[i]);
    end
    cyc(4);
    check("row_wrap", rowwrite, row_exp[0]);
    chk_status("rst_status", 4'b0000);
    chk_data("rst_data", 4'h0);

    // Single clean press of key 9
    keys = 16'h0001 << 9;
    cyc(96);
    chk_status("k9_status", 4'b0001);
    chk_data("k9_data", 4'h9);
    keys = 16'h0000;
    cyc(96);
    pop();
    chk_status("k9_popped", 4'b0000);
    chk_data("k9_empty_data", 4'h0);

    // One-frame bounce is rejected
    keys = 16'h0001 << 5;
    cyc(16);
    keys = 16'h0000;
    cyc(96);
    chk_status("bounce", 4'b0000);

    // Five presses into a four-entry FIFO
    tap(1); tap(2); tap(3); tap(4); tap(6);
    chk_status("ovf_status", 4'b1001);
    chk_data("fifo_h1", 4'h1);
    pop();
    chk_status("ovf_cleared", 4'b0001);
    chk_data("fifo_h2", 4'h2);
    pop();
    chk_data("fifo_h3", 4'h3);
    pop();
    chk_data("fifo_h4", 4'h4);
    pop();
    chk_status("fifo_drained", 4'b0000);

    // Long ack pops exactly once
    tap(7); tap(8);
    ack = 1'b1;
    cyc(20);
    ack = 1'b0;
    cyc(1);
    chk_data("long_ack", 4'h8);
    chk_status("long_ack_st", 4'b0001);
    pop();
    chk_status("long_ack_empty", 4'b0000);

    // Push and pop in the same cycle on a full FIFO
    tap(10); tap(11); tap(12); tap(13);
    chk_data("full_head", 4'hA);
    last    = rowwrite;
    aligned = 1'b0;
    for (int i = 0; i < 64 && !aligned; i++) begin
      cyc(1);
      if (rowwrite == 4'b1110 && last == 4'b0111) aligned = 1'b1;
      else last = rowwrite;
    end
    check("frame_align", {3'b000, aligned}, 4'b0001);
    keys = 16'h0001 << 14;
    cyc(48);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    keys = 16'h0000;
    cyc(80);
    chk_status("simul_status", 4'b0001);
    chk_data("simul_e1", 4'hB);
    pop();
    chk_data("simul_e2", 4'hC);
    pop();
    chk_data("simul_e3", 4'hD);
    pop();
    chk_data("simul_e4", 4'hE);
    pop();
    chk_status("simul_empty", 4'b0000);

    // Long hold of key F
    keys = 16'h0001 << 15;
    cyc(320);
    keys = 16'h0000;
    cyc(80);
    chk_data("holdF_first", 4'hF);
    pop();
`ifdef KEYSCAN_REPEAT_EN
    chk_data("holdF_repeat", 4'hF);
`else
    chk_status("holdF_single", 4'b0000);
`endif

    // Reset in the middle of a debounce
    keys = 16'h0001;
    cyc(40);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    keys = 16'h0000;
    check("midrst_row", rowwrite, 4'b1110);
    chk_status("midrst_status", 4'b0000);
    chk_data("midrst_data", 4'h0);
    cyc(96);
    chk_status("midrst_nopush", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Memory-mapped 4x4 matrix keypad front end; sits directly upstream of the CPU input multiplexer.
- Drives keypad rows, samples columns, debounces, and queues key codes in a small FIFO.
- Exposes a status/data read port: the CPU address decoder asserts statusordata for KEYPAD+1 and ack for KEYPAD.
- Key codes also feed the seven-segment display block.

Parameters:
SCAN_DIV, 1000, clk cycles each row is driven before columns are sampled (>=2)
DEBOUNCE_SCANS, 4, consecutive identical full-frame results required to accept a state (>=1)
FIFO_DEPTH, 4, key-code FIFO entries (power of 2, >=2)
REPEAT_SCANS, 50, frames between auto-repeat pushes (used only with KEYSCAN_REPEAT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rowwrite  output  4  row drive, active-low, exactly one bit low at any time
colread  input  4  column sense, active-low (pulled up externally), asynchronous
ack  input  1  level from address decoder; its rising edge pops one FIFO entry
statusordata  input  1  1: keyout shows status; 0: keyout shows FIFO head
keyout  output  4  status {overflow, 2'b00, not_empty} or head key code

Behaviour:
- Reset values:
  - rowwrite=4'b1110 (row 0); scan counter=0.
  - Stable state=NONE; debounce count=0.
  - FIFO empty, rd/wr pointers=0, overflow=0.
  - keyout=4'h0 in both modes.
- Input sync: colread passes through a 2-flop synchronizer before any use.
- Scan:
  - Row r is driven low for SCAN_DIV cycles, r=0..3, wrapping 3->0.
  - The synced columns are sampled on the last cycle of each row period.
  - Four row periods make one frame of 4*SCAN_DIV cycles.
- Frame result:
  - Code = 4*r + c for the lowest-indexed (r,c) with the column low.
  - Several keys down: the lowest code wins.
  - No key down: result NONE.
- Debounce:
  - At frame end, a result equal to the previous frame's result increments the count (saturating at DEBOUNCE_SCANS); otherwise the count resets to 1.
  - When the count reaches DEBOUNCE_SCANS and the result differs from the stable state, the stable state takes that result.
- Push:
  - Generated on the cycle after frame end, whenever the stable state changes to a code (NONE->k, or k1->k2).
  - A change to NONE never pushes.
- FIFO full on push: code dropped, overflow set (sticky).
- Pop:
  - Occurs when ack is high and its registered previous value is low.
  - Holding ack high for many cycles pops exactly once.
  - Pop on empty: ignored, pointers unchanged.
- Overflow is cleared by any successful pop.
- Push and pop in the same cycle:
  - Full: pop then push; no overflow; count unchanged.
  - Empty: push succeeds, pop ignored.
- keyout is combinational from statusordata, FIFO head, and flags. Data mode on empty returns 4'h0.
- Latency: a clean press is visible at the FIFO head within DEBOUNCE_SCANS+1 frames + 1 cycle.
- Reset mid-scan or mid-debounce: all state returns to reset values in the next cycle; no partial push.

Optional Feature:
- Macro: KEYSCAN_REPEAT_EN.
- Defined:
  - While the stable state holds the same code, the block re-pushes that code every REPEAT_SCANS frames after the initial push.
  - The repeat counter clears on any stable-state change.
  - Overflow rules apply to repeat pushes.
- Undefined: exactly one push per accepted press; REPEAT_SCANS is ignored; no repeat logic is synthesized.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, REPEAT_SCANS=5):
- Reset release, no key -> rowwrite cycles 1110,1101,1011,0111 every 4 clk; status=4'b0000; data=4'h0.
- Hold row2/col1 (colread[1] low while rowwrite[2] low) -> after 4 frames, status=4'b0001 and data=4'h9; pulse ack -> status=4'b0000.
- Bounce key 5 for 1 frame, release -> no push; status stays 4'b0000.
- Press and release keys 1,2,3,4,6 with no pops -> status=4'b1001; pops return 1,2,3,4; after the first pop, overflow=0.
- ack held high 20 cycles with 2 entries -> one pop only; simultaneous push and pop on a full FIFO -> count stays 4, overflow 0.
- KEYSCAN_REPEAT_EN defined, hold key 0xF for 20 frames -> initial push, then pushes every 5 frames until full. Undefined -> exactly one push.
